// File: rtl/zeroheti_obi_addr_demux.sv
`default_nettype none
// ============================================================================
// Module  : zeroheti_obi_addr_demux
// Brief   : 1-to-NUM_SBR OBI demux with address decode, ordered outstanding
//           tracking and an internal error subordinate for unmapped addresses.
// Revision: 1.0
// ============================================================================
module zeroheti_obi_addr_demux #(
  parameter int unsigned                    NUM_SBR    = 4,
  parameter int unsigned                    ADDR_WIDTH = 32,
  parameter int unsigned                    DATA_WIDTH = 32,
  parameter int unsigned                    MAX_TRANS  = 4,
  parameter logic [NUM_SBR*ADDR_WIDTH-1:0]  SBR_BASE   = '0,
  parameter logic [NUM_SBR*ADDR_WIDTH-1:0]  SBR_MASK   = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          mgr_req_i,
  output logic                          mgr_gnt_o,
  input  logic [ADDR_WIDTH-1:0]         mgr_addr_i,
  input  logic                          mgr_we_i,
  input  logic [DATA_WIDTH/8-1:0]       mgr_be_i,
  input  logic [DATA_WIDTH-1:0]         mgr_wdata_i,
  output logic                          mgr_rvalid_o,
  output logic [DATA_WIDTH-1:0]         mgr_rdata_o,
  output logic                          mgr_err_o,
  output logic [NUM_SBR-1:0]            sbr_req_o,
  input  logic [NUM_SBR-1:0]            sbr_gnt_i,
  output logic [ADDR_WIDTH-1:0]         sbr_addr_o,
  output logic                          sbr_we_o,
  output logic [DATA_WIDTH/8-1:0]       sbr_be_o,
  output logic [DATA_WIDTH-1:0]         sbr_wdata_o,
  input  logic [NUM_SBR-1:0]            sbr_rvalid_i,
  input  logic [NUM_SBR*DATA_WIDTH-1:0] sbr_rdata_i,
  input  logic [NUM_SBR-1:0]            sbr_err_i,
  output logic                          busy_o
);

  localparam int unsigned c_cnt_w = $clog2(MAX_TRANS + 1);
  localparam int unsigned c_tgt_w = $clog2(NUM_SBR + 1);
  localparam logic [c_tgt_w-1:0] c_err_idx = c_tgt_w'(NUM_SBR);

  logic [c_cnt_w-1:0]    r_cnt;
  logic [c_tgt_w-1:0]    r_tgt;
  logic                  r_err_rv;

  logic [NUM_SBR-1:0]    w_hit;
  logic [NUM_SBR-1:0]    w_sel_onehot;
  logic [NUM_SBR-1:0]    w_tgt_onehot;
  logic [c_tgt_w-1:0]    w_sel;
  logic                  w_sel_is_err;
  logic                  w_tgt_is_err;
  logic                  w_sel_gnt;
  logic                  w_may_issue;
  logic                  w_accept;
  logic                  w_raw_resp;
  logic                  w_resp;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_err;

  generate
    for (genvar i = 0; i < NUM_SBR; i++) begin : g_port
      assign w_hit[i] = (mgr_addr_i & SBR_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])
                        == SBR_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_sel_onehot[i] = (w_sel == c_tgt_w'(i));
      assign w_tgt_onehot[i] = (r_tgt == c_tgt_w'(i));
    end
  endgenerate

  // Scan downwards so the lowest matching port wins on overlapping maps.
  always_comb begin
    w_sel = c_err_idx;
    for (int i = int'(NUM_SBR) - 1; i >= 0; i--) begin
      if (w_hit[i]) w_sel = c_tgt_w'(i);
    end
  end

  assign w_sel_is_err = (w_sel == c_err_idx);
  assign w_tgt_is_err = (r_tgt == c_err_idx);
  assign w_sel_gnt    = w_sel_is_err | (|(w_sel_onehot & sbr_gnt_i));

  // A new target is only reachable once every response from the old one is back.
  assign w_may_issue = rst_ni & ((r_cnt == '0) |
                       ((r_cnt < c_cnt_w'(MAX_TRANS)) & (w_sel == r_tgt)));

  assign sbr_req_o = {NUM_SBR{mgr_req_i & w_may_issue}} & w_sel_onehot;
  assign mgr_gnt_o = w_may_issue & w_sel_gnt;
  assign w_accept  = mgr_req_i & mgr_gnt_o;

  assign sbr_addr_o  = mgr_addr_i;
  assign sbr_we_o    = mgr_we_i;
  assign sbr_be_o    = mgr_be_i;
  assign sbr_wdata_o = mgr_wdata_i;

  assign w_raw_resp = w_tgt_is_err ? r_err_rv : |(sbr_rvalid_i & w_tgt_onehot);
  assign w_resp     = w_raw_resp & (r_cnt != '0);

  always_comb begin
    w_rdata = '0;
    w_err   = w_tgt_is_err;
    for (int i = 0; i < int'(NUM_SBR); i++) begin
      if (w_tgt_onehot[i]) begin
        w_rdata = sbr_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        w_err   = sbr_err_i[i];
      end
    end
  end

  assign mgr_rvalid_o = w_resp;
  assign mgr_rdata_o  = w_resp ? w_rdata : '0;
  assign mgr_err_o    = w_resp & w_err;
  assign busy_o       = (r_cnt != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt    <= '0;
      r_tgt    <= '0;
      r_err_rv <= 1'b0;
    end else begin
      if (w_accept && !w_resp) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end else if (!w_accept && w_resp) begin
        r_cnt <= r_cnt - c_cnt_w'(1);
      end
      if (w_accept) r_tgt <= w_sel;
      r_err_rv <= w_accept & w_sel_is_err;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(w_raw_resp && (r_cnt == '0)))
        else $error("response with no outstanding transaction");
      assert ((r_cnt == '0) || ((sbr_rvalid_i & ~w_tgt_onehot) == '0))
        else $error("response from non-target port dropped");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_zeroheti_obi_addr_demux.sv
`default_nettype none
// Directed bench: 2 ports (port0 0x0000_0xxx, port1 0x....1xxx), 4 outstanding max.
module tb_zeroheti_obi_addr_demux;

  logic        clk;
  logic        rst_n;
  logic        mgr_req;
  logic        mgr_gnt;
  logic [31:0] mgr_addr;
  logic        mgr_we;
  logic [3:0]  mgr_be;
  logic [31:0] mgr_wdata;
  logic        mgr_rvalid;
  logic [31:0] mgr_rdata;
  logic        mgr_err;
  logic [1:0]  sbr_req;
  logic [1:0]  sbr_gnt;
  logic [31:0] sbr_addr;
  logic        sbr_we;
  logic [3:0]  sbr_be;
  logic [31:0] sbr_wdata;
  logic [1:0]  sbr_rvalid;
  logic [63:0] sbr_rdata;
  logic [1:0]  sbr_err;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt [6] = '{0, 1, 2, 2, 2, 1};

  zeroheti_obi_addr_demux #(
    .NUM_SBR    (2),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MAX_TRANS  (4),
    .SBR_BASE   ({32'h0000_1000, 32'h0000_0000}),
    .SBR_MASK   ({32'h0000_F000, 32'hFFFF_F000})
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mgr_req_i    (mgr_req),
    .mgr_gnt_o    (mgr_gnt),
    .mgr_addr_i   (mgr_addr),
    .mgr_we_i     (mgr_we),
    .mgr_be_i     (mgr_be),
    .mgr_wdata_i  (mgr_wdata),
    .mgr_rvalid_o (mgr_rvalid),
    .mgr_rdata_o  (mgr_rdata),
    .mgr_err_o    (mgr_err),
    .sbr_req_o    (sbr_req),
    .sbr_gnt_i    (sbr_gnt),
    .sbr_addr_o   (sbr_addr),
    .sbr_we_o     (sbr_we),
    .sbr_be_o     (sbr_be),
    .sbr_wdata_o  (sbr_wdata),
    .sbr_rvalid_i (sbr_rvalid),
    .sbr_rdata_i  (sbr_rdata),
    .sbr_err_i    (sbr_err),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    rst_n = 1'b0; mgr_req = 1'b1; mgr_addr = 32'h1000; mgr_we = 1'b0;
    mgr_be = 4'hF; mgr_wdata = '0; sbr_gnt = 2'b11; sbr_rvalid = '0;
    sbr_rdata = '0; sbr_err = '0;

    // Reset held with a pending request
    #2;
    chk("t1_req", 64'(sbr_req), 64'd0);
    chk("t1_gnt", 64'(mgr_gnt), 64'd0);
    chk("t1_rvalid", 64'(mgr_rvalid), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_rdata", 64'(mgr_rdata), 64'd0);
    tick(); tick();
    chk("t1_req_hold", 64'(sbr_req), 64'd0);
    mgr_req = 1'b0;
    rst_n   = 1'b1;
    #1;
    chk("t1_req_idle", 64'(sbr_req), 64'd0);
    tick();

    // Pipelined reads to port1, responses two cycles after grant
    for (int k = 0; k < 6; k++) begin
      mgr_req    = (k < 4);
      mgr_addr   = 32'h1000 + 32'(4 * k);
      mgr_we     = (k == 0);
      mgr_be     = (k == 0) ? 4'h5 : 4'hF;
      mgr_wdata  = 32'hCAFE_F00D;
      sbr_rvalid = (k >= 2) ? 2'b10 : 2'b00;
      sbr_rdata  = {32'hA000 + 32'(k) - 32'd2, 32'h0};
      #1;
      chk("t2_cnt", 64'(dut.r_cnt), 64'(exp_cnt[k]));
      chk("t2_req", 64'(sbr_req), (k < 4) ? 64'h2 : 64'h0);
      chk("t2_rvalid", 64'(mgr_rvalid), (k >= 2) ? 64'd1 : 64'd0);
      chk("t2_rdata", 64'(mgr_rdata), (k >= 2) ? 64'(32'hA000 + k - 2) : 64'd0);
      if (k < 4) chk("t2_gnt", 64'(mgr_gnt), 64'd1);
      if (k == 0) begin
        chk("t2_bcast", {sbr_addr, sbr_wdata}, {32'h1000, 32'hCAFE_F00D});
        chk("t2_bcast_we_be", {59'd0, sbr_we, sbr_be}, 64'h15);
      end
      tick();
    end
    sbr_rvalid = '0;
    #1;
    chk("t2_busy_end", 64'(busy), 64'd0);
    tick();

    // Port0 never responds: outstanding limit blocks the fifth read
    mgr_addr = 32'h0000_0100; mgr_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mgr_req = 1'b1;
      #1;
      chk("t3_gnt", 64'(mgr_gnt), (k < 4) ? 64'd1 : 64'd0);
      chk("t3_req", 64'(sbr_req), (k < 4) ? 64'h1 : 64'h0);
      tick();
    end
    mgr_req = 1'b0;
    #1;
    chk("t3_busy", 64'(busy), 64'd1);
    chk("t3_cnt", 64'(dut.r_cnt), 64'd4);
    tick();
    for (int k = 0; k < 4; k++) begin
      sbr_rvalid = 2'b01;
      sbr_rdata  = {32'h0, 32'h3000 + 32'(k)};
      #1;
      chk("t3_drain", {31'd0, mgr_rvalid, mgr_rdata}, {31'd0, 1'b1, 32'h3000 + 32'(k)});
      tick();
    end
    sbr_rvalid = '0;
    #1;
    chk("t3_busy_end", 64'(busy), 64'd0);
    tick();

    // Target switch held until port0 has drained
    mgr_req = 1'b1; mgr_addr = 32'h0000_0100;
    #1;
    chk("t4_req0", 64'(sbr_req), 64'h1);
    tick();
    mgr_addr = 32'h0000_1000;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t4_hold_req", 64'(sbr_req), 64'h0);
      chk("t4_hold_gnt", 64'(mgr_gnt), 64'd0);
      tick();
    end
    sbr_rvalid = 2'b01; sbr_rdata = {32'h0, 32'h5555};
    #1;
    chk("t4_resp_cycle_req", 64'(sbr_req), 64'h0);
    chk("t4_resp0", {31'd0, mgr_rvalid, mgr_rdata}, {31'd0, 1'b1, 32'h5555});
    tick();
    sbr_rvalid = '0;
    #1;
    chk("t4_req1", 64'(sbr_req), 64'h2);
    chk("t4_gnt1", 64'(mgr_gnt), 64'd1);
    tick();
    mgr_req = 1'b0; sbr_rvalid = 2'b10; sbr_rdata = {32'h6666, 32'h0};
    #1;
    chk("t4_resp1", {31'd0, mgr_rvalid, mgr_rdata}, {31'd0, 1'b1, 32'h6666});
    tick();
    sbr_rvalid = '0;
    #1;
    chk("t4_busy_end", 64'(busy), 64'd0);
    tick();

    // Unmapped address: internal error subordinate, back-to-back
    sbr_gnt = 2'b00; mgr_req = 1'b1; mgr_addr = 32'hDEAD_0000;
    #1;
    chk("t5_gnt", 64'(mgr_gnt), 64'd1);
    chk("t5_req", 64'(sbr_req), 64'h0);
    tick();
    #1;
    chk("t5_gnt2", 64'(mgr_gnt), 64'd1);
    chk("t5_resp1", {30'd0, mgr_rvalid, mgr_err, mgr_rdata}, {30'd0, 2'b11, 32'h0});
    tick();
    mgr_req = 1'b0;
    #1;
    chk("t5_resp2", {30'd0, mgr_rvalid, mgr_err, mgr_rdata}, {30'd0, 2'b11, 32'h0});
    tick();
    #1;
    chk("t5_idle", {62'd0, mgr_rvalid, busy}, 64'd0);
    tick();

    // Accept and response together, then reset with two outstanding
    sbr_gnt = 2'b11; mgr_req = 1'b1; mgr_addr = 32'h0000_1000;
    #1;
    chk("t6_req", 64'(sbr_req), 64'h2);
    tick();
    sbr_rvalid = 2'b10; sbr_err = 2'b10; sbr_rdata = {32'h7777, 32'h0};
    #1;
    chk("t6_cnt1", 64'(dut.r_cnt), 64'd1);
    chk("t6_resp_err", {30'd0, mgr_rvalid, mgr_err, mgr_rdata}, {30'd0, 2'b11, 32'h7777});
    tick();
    sbr_rvalid = '0; sbr_err = '0;
    #1;
    chk("t6_cnt_same", 64'(dut.r_cnt), 64'd1);
    tick();
    mgr_req = 1'b0;
    #1;
    chk("t6_cnt2", 64'(dut.r_cnt), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_cnt", 64'(dut.r_cnt), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    tick();
    rst_n = 1'b1; sbr_rvalid = 2'b10; sbr_rdata = {32'h8888, 32'h0};
    #1;
    chk("t6_late_resp", {31'd0, mgr_rvalid, mgr_rdata}, 64'd0);
    tick();
    sbr_rvalid = '0;
    #1;
    chk("t6_late_cnt", 64'(dut.r_cnt), 64'd0);
    chk("t6_late_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
